// File: rtl/up_down_counter.sv
// Loadable WIDTH-bit binary up/down counter that wraps modulo 2^WIDTH in both directions.
// Priority on each rising edge: synchronous reset, then parallel load, then one count step.
module up_down_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld,
  input  logic             U_D,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;

  // Natural overflow of the WIDTH-bit add/subtract provides the wrap-around.
  always_comb begin
    w_count_nxt = r_count;
    if (ld) begin
      w_count_nxt = data_in;
    end else if (U_D) begin
      w_count_nxt = r_count + WIDTH'(1);
    end else begin
      w_count_nxt = r_count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter (WIDTH = 3): directed plan plus random steps.
// Expected values are queued when stimulus is driven and popped when count is sampled.
module tb_up_down_counter;

  localparam int W = 3;
  localparam int MODV = 1 << W;

  logic         clk;
  logic         reset_n;
  logic         ld;
  logic         U_D;
  logic [W-1:0] data_in;
  logic [W-1:0] count;

  typedef struct {
    string        tag;
    logic [W-1:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_tests = 0;
  int       n_fail  = 0;
  int       m_count = 0;

  up_down_counter #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (ld),
    .U_D     (U_D),
    .data_in (data_in),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: count=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // exp >= 0 gives an explicit expected value; exp < 0 asks the reference model.
  task automatic step(input string tag, input bit rn, input bit l, input bit ud,
                      input int din, input int exp);
    sb_item_t it;
    int       nxt;
    @(negedge clk);
    reset_n = rn;
    ld      = l;
    U_D     = ud;
    data_in = W'(din);
    if (!rn)      nxt = 0;
    else if (l)   nxt = din % MODV;
    else if (ud)  nxt = (m_count + 1) % MODV;
    else          nxt = (m_count + MODV - 1) % MODV;
    if (exp >= 0) nxt = exp;
    m_count = nxt;
    it.tag = tag;
    it.exp = W'(nxt);
    sb_q.push_back(it);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty at sample time", tag);
    end else begin
      it = sb_q.pop_front();
      check_eq(it.tag, count, it.exp);
    end
  endtask

  initial begin
    reset_n = 1'b1;
    ld      = 1'b0;
    U_D     = 1'b1;
    data_in = '0;

    step("rst_over_ld", 0, 1, 1, 5, 0);

    step("load5",  1, 1, 1, 5, 5);
    step("up6",    1, 0, 1, 0, 6);
    step("up7",    1, 0, 1, 0, 7);
    step("up_wrap",1, 0, 1, 0, 0);
    step("up1",    1, 0, 1, 0, 1);

    step("rst_dn", 0, 0, 0, 0, 0);
    step("dn_wrap",1, 0, 0, 0, 7);
    step("dn6",    1, 0, 0, 0, 6);
    step("dn5",    1, 0, 0, 0, 5);
    step("dn4",    1, 0, 0, 0, 4);
    step("sw_up5", 1, 0, 1, 0, 5);
    step("sw_up6", 1, 0, 1, 0, 6);
    step("sw_up7", 1, 0, 1, 0, 7);
    step("sw_up0", 1, 0, 1, 0, 0);

    step("rst_lp", 0, 0, 1, 0, 0);
    step("lp_up1", 1, 0, 1, 0, 1);
    step("lp_up2", 1, 0, 1, 0, 2);
    step("ld6_a",  1, 1, 1, 6, 6);
    step("ld6_b",  1, 1, 1, 6, 6);
    step("lp_up7", 1, 0, 1, 0, 7);
    step("lp_up0", 1, 0, 1, 0, 0);

    step("ld_track3", 1, 1, 0, 3, 3);
    step("ld_track1", 1, 1, 0, 1, 1);
    step("ld_dn0",    1, 0, 0, 0, 0);

    step("rst_mid",  0, 0, 1, 0, 0);
    step("mid_up1",  1, 0, 1, 0, 1);
    step("mid_up2",  1, 0, 1, 0, 2);
    step("mid_up3",  1, 0, 1, 0, 3);
    step("mid_rst_a",0, 1, 0, 5, 0);
    step("mid_rst_b",0, 0, 0, 0, 0);
    step("rel_up1",  1, 0, 1, 0, 1);
    step("rel_up2",  1, 0, 1, 0, 2);

    // A reset_n pulse between edges must not disturb the register.
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    #1;
    check_eq("async_rst_glitch", count, W'(2));
    step("post_glitch_up3", 1, 0, 1, 0, 3);

    for (int i = 0; i < 40; i++) begin
      step($sformatf("rand%0d", i), ($urandom_range(7) != 0), ($urandom_range(3) == 0),
           1'($urandom_range(1)), int'($urandom_range(MODV - 1)), -1);
    end

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
